// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Purpose  : Valid/ready FIFO holding ALU result words with their status
//            flags, plus a sticky OR of the flags of every accepted result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_y,
    input  logic                         in_cout,
    input  logic                         in_neg,
    input  logic                         in_zero,
    input  logic                         in_ovf,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_y,
    output logic [3:0]                   out_flags,
    output logic [3:0]                   sticky_flags,
    input  logic                         sticky_clr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = WIDTH + 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [3:0]         r_sticky;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;
    logic [3:0]         w_in_flags;
    logic [ENT_W-1:0]   w_head;

    assign w_in_flags   = {in_ovf, in_zero, in_neg, in_cout};
    assign in_ready     = (r_state != ST_FULL);
    assign out_valid    = (r_state != ST_EMPTY);
    assign w_push       = in_valid && in_ready;
    assign w_pop        = out_ready && out_valid;
    assign w_head       = r_mem[r_rd_ptr];
    assign out_y        = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_flags    = out_valid ? w_head[ENT_W-1:WIDTH] : 4'd0;
    assign sticky_flags = r_sticky;
    assign count        = r_count;

    // Storage is deliberately not reset; stale entries are unreachable once
    // the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_in_flags, in_y};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sticky <= 4'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A clear colliding with a push keeps only that push's flags.
            if (sticky_clr) begin
                r_sticky <= w_push ? w_in_flags : 4'd0;
            end else if (w_push) begin
                r_sticky <= r_sticky | w_in_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (w_push && !w_pop && (r_count == CNT_W'(DEPTH - 1))) begin
                    w_state_nxt = ST_FULL;
                end else if (w_pop && !w_push && (r_count == CNT_W'(1))) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt = ST_PARTIAL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// Testbench for alu_result_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_y;
    logic              in_cout;
    logic              in_neg;
    logic              in_zero;
    logic              in_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_y;
    logic [3:0]        out_flags;
    logic [3:0]        sticky_flags;
    logic              sticky_clr;
    logic [2:0]        count;

    int checks;
    int failures;

    // Reference model: queue of {flags, y} plus sticky accumulator.
    logic [WIDTH+3:0]  mq[$];
    logic [3:0]        msticky;

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_y         (in_y),
        .in_cout      (in_cout),
        .in_neg       (in_neg),
        .in_zero      (in_zero),
        .in_ovf       (in_ovf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [WIDTH-1:0] y, input logic [3:0] f);
        in_valid = v;
        in_y     = y;
        in_ovf   = f[3];
        in_zero  = f[2];
        in_neg   = f[1];
        in_cout  = f[0];
    endtask

    // One clock cycle; the model applies the handshake rules to the inputs
    // that were stable before the edge.
    task automatic tick();
        bit               push;
        bit               pop;
        bit               clr;
        logic [WIDTH+3:0] e;
        push = in_valid && (mq.size() < DEPTH);
        pop  = out_ready && (mq.size() > 0);
        clr  = sticky_clr;
        e    = {in_ovf, in_zero, in_neg, in_cout, in_y};
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        if (clr) msticky = push ? e[WIDTH+3:WIDTH] : 4'd0;
        else if (push) msticky = msticky | e[WIDTH+3:WIDTH];
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 4'd0);
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== '0
            || out_flags !== 4'd0 || sticky_flags !== 4'd0) begin
            failures++;
            $display("FAIL reset_initial: count=%0d ov=%b ir=%b y=%h f=%b st=%b, required 0 0 1 0 0 0",
                     count, out_valid, in_ready, out_y, out_flags, sticky_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        msticky = 4'd0;
        #1;
        // Three entries stored, then an asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, (i == 0) ? 4'b0100 : 4'($urandom));
            tick();
        end
        drive(1'b0, '0, 4'd0);
        checks++;
        if (count !== 3'd3 || sticky_flags !== msticky) begin
            failures++;
            $display("FAIL reset_prefill: count=%0d st=%b, required 3 %b", count, sticky_flags, msticky);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_y !== '0 || in_ready !== 1'b1
            || sticky_flags !== 4'd0 || out_flags !== 4'd0) begin
            failures++;
            $display("FAIL reset_async: count=%0d ov=%b y=%h ir=%b st=%b f=%b, required 0 0 0 1 0 0",
                     count, out_valid, out_y, in_ready, sticky_flags, out_flags);
        end
        mq.delete();
        msticky = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] exp_seq [4];
        exp_seq[0] = 32'd2; exp_seq[1] = 32'd3; exp_seq[2] = 32'd4; exp_seq[3] = 32'd5;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, WIDTH'(i), 4'd0);
            tick();
            checks++;
            if (count !== 3'(i)) begin
                failures++;
                $display("FAIL fill_count: got %0d required %0d", count, i);
            end
        end
        checks++;
        if (in_ready !== 1'b0 || out_y !== 32'd1) begin
            failures++;
            $display("FAIL fill_full: ir=%b y=%h, required 0 1", in_ready, out_y);
        end
        drive(1'b1, 32'd5, 4'd0);
        repeat (2) tick();
        checks++;
        if (count !== 3'd4 || out_y !== 32'd1) begin
            failures++;
            $display("FAIL fill_held: count=%0d y=%h, required 4 1", count, out_y);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_y !== exp_seq[0]) begin
            failures++;
            $display("FAIL drain_first: count=%0d ir=%b y=%h, required 3 1 %h", count, in_ready, out_y, exp_seq[0]);
        end
        tick();
        drive(1'b0, '0, 4'd0);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_y !== exp_seq[i]) begin
                failures++;
                $display("FAIL drain_seq%0d: ov=%b y=%h, required 1 %h", i, out_valid, out_y, exp_seq[i]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || out_y !== '0 || count !== 3'd0) begin
            failures++;
            $display("FAIL drain_empty: ov=%b y=%h count=%0d, required 0 0 0", out_valid, out_y, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h10 + WIDTH'(i), 4'd0);
            tick();
            checks++;
            if (count !== 3'd1 || out_y !== 32'h10 + WIDTH'(i)) begin
                failures++;
                $display("FAIL wrap_%0d: count=%0d y=%h, required 1 %h", i, count, out_y, 32'h10 + i);
            end
        end
        drive(1'b0, '0, 4'd0);
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL wrap_end: ov=%b count=%0d, required 0 0", out_valid, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flags();
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        drive(1'b1, 32'h0, 4'b0100);
        tick();
        drive(1'b1, 32'h8000_0000, 4'b1010);
        tick();
        drive(1'b0, '0, 4'd0);
        checks++;
        if (out_flags !== 4'b0100 || out_y !== 32'h0 || sticky_flags !== 4'b1110) begin
            failures++;
            $display("FAIL flags_first: f=%b y=%h st=%b, required 0100 0 1110", out_flags, out_y, sticky_flags);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_flags !== 4'b1010 || out_y !== 32'h8000_0000 || sticky_flags !== 4'b1110) begin
            failures++;
            $display("FAIL flags_second: f=%b y=%h st=%b, required 1010 80000000 1110", out_flags, out_y, sticky_flags);
        end
    endtask

    task automatic test_sticky_clear();
        sticky_clr = 1'b1;
        drive(1'b1, 32'h1234, 4'b0001);
        tick();
        drive(1'b0, '0, 4'd0);
        checks++;
        if (sticky_flags !== 4'b0001) begin
            failures++;
            $display("FAIL sticky_collide: got %b required 0001", sticky_flags);
        end
        tick();
        sticky_clr = 1'b0;
        checks++;
        if (sticky_flags !== 4'b0000) begin
            failures++;
            $display("FAIL sticky_clear: got %b required 0000", sticky_flags);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8 && mq.size() > 0; i++) tick();
        checks++;
        if (mq.size() != 0 || count !== 3'd0 || sticky_flags !== 4'b0000) begin
            failures++;
            $display("FAIL sticky_drain: count=%0d st=%b, required 0 0000", count, sticky_flags);
        end
    endtask

    task automatic test_empty_pop();
        logic [3:0] st_before;
        st_before = sticky_flags;
        out_ready = 1'b1;
        drive(1'b0, 32'hdead_beef, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (count !== 3'd0 || out_y !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1
                || sticky_flags !== st_before) begin
                failures++;
                $display("FAIL empty_pop_%0d: count=%0d y=%h ov=%b ir=%b st=%b", i, count, out_y,
                         out_valid, in_ready, sticky_flags);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ey;
        logic [3:0]       ef;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 60), $urandom, 4'($urandom));
            out_ready  = ($urandom_range(0, 99) < 50);
            sticky_clr = ($urandom_range(0, 99) < 8);
            tick();
            ey = (mq.size() > 0) ? mq[0][WIDTH-1:0] : '0;
            ef = (mq.size() > 0) ? mq[0][WIDTH+3:WIDTH] : 4'd0;
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH)
                || count !== 3'(mq.size()) || out_y !== ey || out_flags !== ef
                || sticky_flags !== msticky) begin
                failures++;
                $display("FAIL random_%0d: ov=%b ir=%b cnt=%0d y=%h f=%b st=%b, required cnt=%0d y=%h f=%b st=%b",
                         i, out_valid, in_ready, count, out_y, out_flags, sticky_flags,
                         mq.size(), ey, ef, msticky);
            end
        end
        drive(1'b0, '0, 4'd0);
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        msticky  = 4'd0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flags();
        test_sticky_clear();
        test_empty_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream buffering stage for the 32-bit ALU: captures each ALU result word and its four status flags under a valid/ready handshake and holds them in a small FIFO until the consumer (register-file writeback or bench monitor) pops them. It also keeps a sticky flag register: the OR of the flags of every result accepted since the last clear. This decouples the combinational ALU from a consumer that may stall.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2.
- WIDTH, 32: result word width; matches ALU Y.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset is asynchronous and active-low.
- in_valid  input  1  producer presents a result this cycle.
- in_ready  output  1  FIFO can accept; equals !full.
- in_y  input  WIDTH  ALU result Y.
- in_cout, in_neg, in_zero, in_ovf  input  1 each  ALU Cout, Negative, Zero, Overflow.
- out_valid  output  1  head entry present; equals !empty.
- out_ready  input  1  consumer accepts head this cycle.
- out_y  output  WIDTH  head result; 0 when out_valid=0.
- out_flags  output  4  head flags {ovf,zero,neg,cout} in bits [3:0]; 0 when out_valid=0.
- sticky_flags  output  4  accumulated flags, same bit order.
- sticky_clr  input  1  synchronous clear of sticky_flags.
- count  output  clog2(DEPTH+1)  entries currently stored.

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_ovf,in_zero,in_neg,in_cout,in_y} at wr_ptr; wr_ptr+1; count+1.
- Pop: out_valid && out_ready at a rising edge retires head; rd_ptr+1; count−1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
- Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
- Full: in_ready=0, so no push even if a pop occurs that cycle; in_ready rises the cycle after the pop.
- Empty: out_valid=0; out_ready ignored; no pointer movement.
- in_valid while in_ready=0: no write, no state change; producer must hold data (standard handshake).
- Entry ordering strictly FIFO; data and flags of one entry never split.
- Sticky: on each push, sticky_flags <= sticky_flags | pushed flags. sticky_clr=1 clears prior state; if a push occurs in the same cycle, result is exactly that push's flags. Pops never affect sticky_flags.
- Internal states (derived from count): EMPTY, PARTIAL, FULL; EMPTY→PARTIAL on push; PARTIAL→FULL on push-only at count=DEPTH−1; FULL→PARTIAL on pop; PARTIAL→EMPTY on pop-only at count=1.

## Timing
- Reset (rst_n=0, asynchronous, any cycle including mid-transfer): count=0, pointers=0, sticky_flags=0, in_ready=1, out_valid=0, out_y=0, out_flags=0. Stored data discarded; storage array need not be cleared.
- Push-to-visible latency: 1 cycle; entry pushed at edge N is on out_y/out_flags with out_valid=1 after edge N.
- Sustained throughput: one push and one pop per cycle when not full/empty.
- out_y/out_flags/out_valid/in_ready/count/sticky_flags change only on clock edges or reset; no combinational path from in_* to out_* or from out_ready to in_ready.

## Test plan
- Reset: drive rst_n=0 mid-stream with 3 entries stored → immediately count=0, out_valid=0, out_y=0, in_ready=1, sticky_flags=0.
- Fill/drain: push Y=1,2,3,4 with out_ready=0 → count=4, in_ready=0; 5th push of Y=5 held and ignored; then out_ready=1 → out_y 1,2,3,4 on consecutive cycles, then out_valid=0; Y=5 accepted after first pop.
- Wrap-around: 10 push/pop pairs of Y=0x10..0x19 with continuous handshake → output sequence identical, count stays 1 after first cycle, pointers wrap twice.
- Flags: push Y=0 with zero=1, then Y=0x80000000 with neg=1,ovf=1 → out_flags 0100 then 1010; sticky_flags=1110.
- Sticky clear collision: sticky=1110, assert sticky_clr with push carrying cout=1 only → sticky_flags=0001; clr alone next cycle → 0000.
- Empty pop: out_ready=1 with count=0 for 5 cycles → no state change, out_y=0, count=0.
